wb_gain_pipe: RTL and testbench

Parametrised white-balance gain stage for the ISP pixel stream, sitting between demosaic/colour tagging and the gamma stage. It multiplies each pixel by a per-channel fixed-point gain with round-to-nearest and saturation, under a valid/ready handshake with full backpressure. Gain updates are double-buffered so a new gain set takes effect only on a frame boundary. An optional per-frame saturation counter is available.

---
 rtl/wb_gain_pipe.sv | 162 ++++++++++++++++
 tb/tb_wb_gain_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gain_pipe.sv
// White-balance gain stage: per-channel fixed-point gain with rounding and clamping.
// Optional per-frame saturation counter enabled by defining WB_SAT_CNT_EN.
module wb_gain_pipe #(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        color_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              last_i,
    input  logic              gain_load_i,
    input  logic [GAIN_W-1:0] gain_r_i,
    input  logic [GAIN_W-1:0] gain_g_i,
    input  logic [GAIN_W-1:0] gain_b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        color_o,
    output logic [DATA_W-1:0] value_o,
    output logic              last_o,
    output logic              gain_pending_o,
    output logic [15:0]       sat_cnt_o
);
    localparam int P_W = DATA_W + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = {{(GAIN_W-1){1'b0}}, 1'b1} << FRAC_W;
    localparam logic [P_W-1:0]    ROUND = {{(P_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    // Handshake: a beat moves on a rising edge when valid & ready are both high;
    // the whole pipe advances together, so ready upstream mirrors en.
    logic en, accept, commit;
    assign en         = ~out_valid_o | out_ready_i;
    assign in_ready_o = en;
    assign accept     = in_valid_i & en;

    logic [GAIN_W-1:0] act_r, act_g, act_b;
    logic [GAIN_W-1:0] pend_r, pend_g, pend_b;
    logic              frame_active;

    // A last beat still picks up the old gains because S1 samples before commit lands.
    assign commit = gain_pending_o & (accept ? last_i : ~frame_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r          <= UNITY;
            act_g          <= UNITY;
            act_b          <= UNITY;
            pend_r         <= UNITY;
            pend_g         <= UNITY;
            pend_b         <= UNITY;
            gain_pending_o <= 1'b0;
            frame_active   <= 1'b0;
        end else begin
            if (commit) begin
                act_r <= pend_r;
                act_g <= pend_g;
                act_b <= pend_b;
            end
            if (gain_load_i) begin
                pend_r         <= gain_r_i;
                pend_g         <= gain_g_i;
                pend_b         <= gain_b_i;
                gain_pending_o <= 1'b1;
            end else if (commit) begin
                gain_pending_o <= 1'b0;
            end
            if (accept) frame_active <= ~last_i;
        end
    end

    logic [GAIN_W-1:0] sel_gain;
    always_comb begin
        sel_gain = UNITY;
        case (color_i)
            2'd0:    sel_gain = act_r;
            2'd1:    sel_gain = act_g;
            2'd2:    sel_gain = act_b;
            default: sel_gain = UNITY;
        endcase
    end

    logic              s1_valid, s1_last;
    logic [1:0]        s1_color;
    logic [DATA_W-1:0] s1_value;
    logic [GAIN_W-1:0] s1_gain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_color <= 2'd0;
            s1_value <= '0;
            s1_gain  <= UNITY;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last  <= last_i;
                s1_color <= color_i;
                s1_value <= value_i;
                s1_gain  <= sel_gain;
            end
        end
    end

    logic [P_W-1:0]    prod, rnd, shifted;
    logic              res_sat;
    logic [DATA_W-1:0] res_value;
    always_comb begin
        prod      = {{GAIN_W{1'b0}}, s1_value} * {{DATA_W{1'b0}}, s1_gain};
        rnd       = prod + ROUND;
        shifted   = rnd >> FRAC_W;
        res_sat   = |shifted[P_W-1:DATA_W];
        res_value = res_sat ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            color_o     <= 2'd0;
            value_o     <= '0;
            last_o      <= 1'b0;
        end else if (en) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                color_o <= s1_color;
                value_o <= res_value;
                last_o  <= s1_last;
            end
        end
    end

`ifdef WB_SAT_CNT_EN
    logic        s2_sat, xfer;
    logic [15:0] sat_acc, sat_cnt_q, sat_next;
    assign xfer     = out_valid_o & out_ready_i;
    assign sat_next = (s2_sat && sat_acc != 16'hFFFF) ? sat_acc + 16'd1 : sat_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sat    <= 1'b0;
            sat_acc   <= 16'd0;
            sat_cnt_q <= 16'd0;
        end else begin
            if (en && s1_valid) s2_sat <= res_sat;
            if (xfer) begin
                if (last_o) begin
                    sat_cnt_q <= sat_next;
                    sat_acc   <= 16'd0;
                end else begin
                    sat_acc   <= sat_next;
                end
            end
        end
    end
    assign sat_cnt_o = sat_cnt_q;
`else
    assign sat_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_wb_gain_pipe.sv
// Directed bench for wb_gain_pipe: vector table plus stall, gain-commit, saturation-count and reset sequences.
module tb_wb_gain_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  color_i = 2'd0;
    logic [7:0]  value_i = 8'd0;
    logic        last_i = 1'b0;
    logic        gain_load_i = 1'b0;
    logic [15:0] gain_r_i = 16'h0100, gain_g_i = 16'h0100, gain_b_i = 16'h0100;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [1:0]  color_o;
    logic [7:0]  value_o;
    logic        last_o;
    logic        gain_pending_o;
    logic [15:0] sat_cnt_o;

    wb_gain_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .color_i(color_i), .value_i(value_i), .last_i(last_i),
        .gain_load_i(gain_load_i), .gain_r_i(gain_r_i), .gain_g_i(gain_g_i), .gain_b_i(gain_b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .color_o(color_o), .value_o(value_o), .last_o(last_o),
        .gain_pending_o(gain_pending_o), .sat_cnt_o(sat_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [10:0] exp_q[$];

    typedef struct {
        logic [1:0]  color;
        logic [7:0]  value;
        logic [15:0] gr, gg, gb;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every transferred beat must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {21'd0, color_o, last_o, value_o}, 32'hFFFF_FFFF);
            end else begin
                check("beat", {21'd0, color_o, last_o, value_o}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_gains(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        gain_r_i = r; gain_g_i = g; gain_b_i = b; gain_load_i = 1'b1;
        @(posedge clk); #1;
        gain_load_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [1:0] c, input logic [7:0] v, input logic l,
                             input logic [7:0] ev, input logic push);
        logic acc;
        int n;
        if (push) exp_q.push_back({c, l, ev});
        in_valid_i = 1'b1; color_i = c; value_i = v; last_i = l;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    logic [7:0] snap_v;
    logic [1:0] snap_c;
    logic       snap_l;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0, 8'd100, 16'h0180, 16'h0100, 16'h0100, 8'd150};
        vecs[1]  = '{2'd2, 8'd200, 16'h0100, 16'h0100, 16'h0200, 8'd255};
        vecs[2]  = '{2'd1, 8'd3,   16'h0100, 16'h0080, 16'h0100, 8'd2};
        vecs[3]  = '{2'd3, 8'd77,  16'h0300, 16'h0300, 16'h0300, 8'd77};
        vecs[4]  = '{2'd0, 8'd170, 16'h0180, 16'h0100, 16'h0100, 8'd255};
        vecs[5]  = '{2'd0, 8'd171, 16'h0180, 16'h0100, 16'h0100, 8'd255};
        vecs[6]  = '{2'd1, 8'd1,   16'h0100, 16'h0080, 16'h0100, 8'd1};
        vecs[7]  = '{2'd2, 8'd1,   16'h0100, 16'h0100, 16'h007F, 8'd0};
        vecs[8]  = '{2'd0, 8'd255, 16'hFFFF, 16'h0100, 16'h0100, 8'd255};
        vecs[9]  = '{2'd1, 8'd0,   16'h0100, 16'hFFFF, 16'h0100, 8'd0};
        vecs[10] = '{2'd3, 8'd255, 16'h0000, 16'h0000, 16'h0000, 8'd255};
        vecs[11] = '{2'd1, 8'd37,  16'h0000, 16'h0100, 16'h0000, 8'd37};

        // Reset state
        #12;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_outputs", {color_o, last_o, value_o}, 0);
        check("rst_pending", gain_pending_o, 0);
        check("rst_sat_cnt", sat_cnt_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: output valid 2 cycles after the acceptance cycle
        set_gains(16'h0180, 16'h0100, 16'h0100);
        send_beat(2'd0, 8'd100, 1'b1, 8'd150, 1'b1);
        @(negedge clk);
        check("lat_cycle1_valid", out_valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_cycle2_valid", out_valid_o, 1);
        check("lat_value", value_o, 150);
        check("lat_color", color_o, 0);
        wait_drain();

        for (int i = 0; i < 12; i++) begin
            set_gains(vecs[i].gr, vecs[i].gg, vecs[i].gb);
            send_beat(vecs[i].color, vecs[i].value, 1'b1, vecs[i].exp, 1'b1);
            wait_drain();
        end

        // 8-beat stream with a 3-cycle downstream stall
        set_gains(16'h0100, 16'h0100, 16'h0100);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_beat(2'(i % 4), 8'(20 * i + 7), (i == 7), 8'(20 * i + 7), 1'b1);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready_i = 1'b0;
                @(negedge clk);
                snap_v = value_o; snap_c = color_o; snap_l = last_o;
                check("stall_in_ready", in_ready_o, 0);
                check("stall_valid", out_valid_o, 1);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready_o, 0);
                    check("stall_hold", {out_valid_o, color_o, last_o, value_o},
                          {1'b1, snap_c, snap_l, snap_v});
                end
                @(posedge clk); #1 out_ready_i = 1'b1;
            end
        join
        wait_drain();

        // Mid-frame gain load only takes effect at the frame boundary
        set_gains(16'h0100, 16'h0100, 16'h0100);
        send_beat(2'd0, 8'd50, 1'b0, 8'd50, 1'b1);
        gain_r_i = 16'h0200; gain_load_i = 1'b1;
        send_beat(2'd0, 8'd50, 1'b0, 8'd50, 1'b1);
        gain_load_i = 1'b0;
        check("midframe_pending1", gain_pending_o, 1);
        send_beat(2'd0, 8'd50, 1'b0, 8'd50, 1'b1);
        check("midframe_pending2", gain_pending_o, 1);
        send_beat(2'd0, 8'd50, 1'b1, 8'd50, 1'b1);
        check("midframe_committed", gain_pending_o, 0);
        send_beat(2'd0, 8'd50, 1'b1, 8'd100, 1'b1);
        wait_drain();
        gain_r_i = 16'h0080; gain_load_i = 1'b1;
        @(posedge clk); #1;
        gain_load_i = 1'b0;
        check("idle_pending", gain_pending_o, 1);
        @(posedge clk); #1;
        check("idle_committed", gain_pending_o, 0);
        send_beat(2'd0, 8'd50, 1'b1, 8'd25, 1'b1);
        wait_drain();

        // Saturation count per frame
        set_gains(16'h0200, 16'h0200, 16'h0200);
        send_beat(2'd0, 8'd200, 1'b0, 8'd255, 1'b1);
        send_beat(2'd1, 8'd100, 1'b0, 8'd200, 1'b1);
        send_beat(2'd2, 8'd150, 1'b0, 8'd255, 1'b1);
        send_beat(2'd0, 8'd255, 1'b0, 8'd255, 1'b1);
        send_beat(2'd1, 8'd10,  1'b1, 8'd20,  1'b1);
        wait_drain();
`ifdef WB_SAT_CNT_EN
        check("sat_cnt_frame1", sat_cnt_o, 3);
`else
        check("sat_cnt_off1", sat_cnt_o, 0);
`endif
        send_beat(2'd0, 8'd10, 1'b0, 8'd20, 1'b1);
        send_beat(2'd1, 8'd20, 1'b0, 8'd40, 1'b1);
        send_beat(2'd2, 8'd30, 1'b1, 8'd60, 1'b1);
        wait_drain();
        check("sat_cnt_frame2", sat_cnt_o, 0);

        // Reset with two beats in flight and a pending gain set
        gain_r_i = 16'h0300; gain_load_i = 1'b1;
        send_beat(2'd0, 8'd60, 1'b0, 8'd0, 1'b0);
        gain_load_i = 1'b0;
        send_beat(2'd0, 8'd61, 1'b0, 8'd0, 1'b0);
        check("pre_rst_valid", out_valid_o, 1);
        check("pre_rst_pending", gain_pending_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid_o, 0);
        check("rst_mid_outputs", {color_o, last_o, value_o}, 0);
        check("rst_mid_pending", gain_pending_o, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_stale", out_valid_o, 0);
        end
        @(posedge clk); #1;
        send_beat(2'd0, 8'd100, 1'b1, 8'd100, 1'b1);
        send_beat(2'd2, 8'd99, 1'b1, 8'd99, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
